// File: rtl/eth_rx_frame.sv
// eth_rx_frame -- byte-level Ethernet receive framer (1000BASE-T, after RGMII capture).
// Strips preamble/SFD, optionally filters on destination MAC, checks the FCS inline
// and forwards DA..payload bytes (FCS excluded) with a per-frame status strobe.
//
// Ports:
//   clk, rst (async, active-low)
//   rx_data[7:0], rx_dv, rx_er     : byte stream from the capture stage
//   out_data[7:0], out_valid       : frame bytes, DA onward, FCS never emitted
//   out_sof                        : with the first DA byte
//   frame_done                     : one-cycle status strobe
//   frame_ok, crc_err, len_err,
//   phy_err, frame_len[10:0]       : status, held until the next frame_done
//
// Build option: define ETH_RX_MAC_FILTER_EN to accept only LOCAL_MAC or broadcast.
//
// state    | meaning
// IDLE     | waiting for rx_dv with a 0x55 byte after a low rx_dv cycle
// PREAMBLE | inside 0x55 run, waiting for SFD 0xD5
// DATA     | frame body, CRC/count/delay line active
// DROP     | discarding until rx_dv falls
`timescale 1ns/1ps
module eth_rx_frame #(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter int          MIN_LEN   = 64,
  parameter int          MAX_LEN   = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        crc_err,
  output logic        len_err,
  output logic        phy_err,
  output logic [10:0] frame_len
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  state_t      state;
  logic [31:0] crc;
  logic [31:0] crc_nxt;
  logic [10:0] cnt;
  logic [10:0] cnt_nxt;
  logic [7:0]  dly [4];
  logic [7:0]  emit_data;
  logic        emit_vld;
  logic        emit_sof;
  logic        phy_lat;
  logic        drop_report;
  logic        dv_low_q;
  logic        over;
  logic        mac_miss;
  logic        kill;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

`ifdef ETH_RX_MAC_FILTER_EN
  logic       uc_ok;
  logic       bc_ok;
  logic [7:0] mac_byte;

  always_comb begin
    case (cnt[2:0])
      3'd0:    mac_byte = LOCAL_MAC[47:40];
      3'd1:    mac_byte = LOCAL_MAC[39:32];
      3'd2:    mac_byte = LOCAL_MAC[31:24];
      3'd3:    mac_byte = LOCAL_MAC[23:16];
      3'd4:    mac_byte = LOCAL_MAC[15:8];
      default: mac_byte = LOCAL_MAC[7:0];
    endcase
    // The decision at DA byte 5 folds in the current byte, since the flags only cover bytes 0..4.
    mac_miss = (cnt == 11'd5) &&
               !(uc_ok && (rx_data == mac_byte)) &&
               !(bc_ok && (rx_data == 8'hFF));
  end
`else
  always_comb mac_miss = 1'b0;
`endif

  always_comb begin
    crc_nxt = crc_byte(crc, rx_data);
    cnt_nxt = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
    over    = (cnt_nxt > MAX_L);
    kill    = over | mac_miss;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      crc         <= 32'hFFFFFFFF;
      cnt         <= '0;
      for (int i = 0; i < 4; i++) dly[i] <= '0;
      emit_data   <= '0;
      emit_vld    <= 1'b0;
      emit_sof    <= 1'b0;
      phy_lat     <= 1'b0;
      drop_report <= 1'b0;
      dv_low_q    <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      crc_err     <= 1'b0;
      len_err     <= 1'b0;
      phy_err     <= 1'b0;
      frame_len   <= '0;
`ifdef ETH_RX_MAC_FILTER_EN
      uc_ok       <= 1'b1;
      bc_ok       <= 1'b1;
`endif
    end else begin
      dv_low_q   <= ~rx_dv;
      frame_done <= 1'b0;
      emit_vld   <= 1'b0;
      emit_sof   <= 1'b0;
      out_valid  <= emit_vld;
      out_sof    <= emit_sof;
      out_data   <= emit_data;

      case (state)
        IDLE: begin
          // A frame already in flight (e.g. after reset release) is ignored until rx_dv drops.
          if (rx_dv) begin
            if (rx_data == 8'h55 && dv_low_q) begin
              state <= PREAMBLE;
            end else begin
              state       <= DROP;
              drop_report <= 1'b0;
            end
          end
        end

        PREAMBLE: begin
          if (!rx_dv) begin
            state <= IDLE;
          end else if (rx_data == 8'hD5) begin
            state   <= DATA;
            cnt     <= '0;
            crc     <= 32'hFFFFFFFF;
            phy_lat <= 1'b0;
`ifdef ETH_RX_MAC_FILTER_EN
            uc_ok   <= 1'b1;
            bc_ok   <= 1'b1;
`endif
          end else if (rx_data != 8'h55) begin
            state       <= DROP;
            drop_report <= 1'b0;
          end
        end

        DATA: begin
          if (!rx_dv) begin
            state      <= IDLE;
            frame_done <= 1'b1;
            frame_len  <= cnt;
            crc_err    <= (crc != CRC_RESIDUE);
            len_err    <= (cnt < MIN_L) || (cnt > MAX_L);
            phy_err    <= phy_lat;
            frame_ok   <= (crc == CRC_RESIDUE) && (cnt >= MIN_L) && (cnt <= MAX_L) && !phy_lat;
          end else begin
            crc     <= crc_nxt;
            cnt     <= cnt_nxt;
            phy_lat <= phy_lat | rx_er;
            dly[0]  <= rx_data;
            dly[1]  <= dly[0];
            dly[2]  <= dly[1];
            dly[3]  <= dly[2];
            // Four bytes held back: the last four of the frame (the FCS) are never emitted.
            if (cnt >= 11'd4) begin
              emit_vld  <= 1'b1;
              emit_data <= dly[3];
              emit_sof  <= (cnt == 11'd4);
            end
`ifdef ETH_RX_MAC_FILTER_EN
            if (cnt < 11'd6) begin
              uc_ok <= uc_ok & (rx_data == mac_byte);
              bc_ok <= bc_ok & (rx_data == 8'hFF);
            end
`endif
            if (kill) begin
              state       <= DROP;
              drop_report <= over;
              emit_vld    <= 1'b0;
              emit_sof    <= 1'b0;
              out_valid   <= 1'b0;
              out_sof     <= 1'b0;
            end
          end
        end

        DROP: begin
          if (!rx_dv) begin
            state <= IDLE;
            if (drop_report) begin
              frame_done <= 1'b1;
              frame_len  <= cnt;
              len_err    <= 1'b1;
              crc_err    <= (crc != CRC_RESIDUE);
              phy_err    <= phy_lat;
              frame_ok   <= 1'b0;
            end
            drop_report <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_frame.sv
// tb_eth_rx_frame -- directed bench for eth_rx_frame: builds frames with a
// reference CRC32 FCS, drives them byte by byte and checks output bytes,
// latency and the per-frame status.
`timescale 1ns/1ps
module tb_eth_rx_frame;

  localparam logic [47:0] MAC_LOCAL = 48'h02_00_00_00_00_01;
  localparam logic [47:0] MAC_BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MAC_OTHER = 48'h02_00_00_00_00_02;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        frame_done;
  logic        frame_ok;
  logic        crc_err;
  logic        len_err;
  logic        phy_err;
  logic [10:0] frame_len;

  eth_rx_frame dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_dv      (rx_dv),
    .rx_er      (rx_er),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .crc_err    (crc_err),
    .len_err    (len_err),
    .phy_err    (phy_err),
    .frame_len  (frame_len)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: counts emitted bytes, checks them against the expected frame body.
  logic [7:0] exp_q [$];
  logic [7:0] frm [$];
  int         ov_cnt = 0, sof_cnt = 0, done_cnt = 0, data_bad = 0, mon_idx = 0;
  int         sof_cyc = 0, da0_cyc = 0;
  logic [7:0] sof_byte = 8'h00;

  always @(negedge clk) begin
    if (out_valid) begin
      if (out_sof) begin
        mon_idx  = 0;
        sof_cnt++;
        sof_byte = out_data;
        sof_cyc  = cyc;
      end
      if (mon_idx >= exp_q.size() || out_data != exp_q[mon_idx]) data_bad++;
      mon_idx++;
      ov_cnt++;
    end
    if (frame_done) done_cnt++;
  end

  int ov0, sof0, done0, bad0;
  task automatic snap();
    ov0   = ov_cnt;
    sof0  = sof_cnt;
    done0 = done_cnt;
    bad0  = data_bad;
  endtask

  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++)
      r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // len = total bytes DA..FCS
  task automatic build(input logic [47:0] da, input int len);
    logic [31:0] c;
    logic [31:0] fcs;
    frm = {};
    for (int i = 5; i >= 0; i--) frm.push_back(da[8*i +: 8]);
    frm.push_back(8'h02); frm.push_back(8'h00); frm.push_back(8'h00);
    frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h99);
    frm.push_back(8'h08); frm.push_back(8'h00);
    for (int i = 0; i < len - 18; i++) frm.push_back(8'((i * 7 + 3) & 255));
    exp_q = frm;
    c = 32'hFFFFFFFF;
    foreach (frm[i]) c = ref_crc(c, frm[i]);
    fcs = ~c;
    frm.push_back(fcs[7:0]);
    frm.push_back(fcs[15:8]);
    frm.push_back(fcs[23:16]);
    frm.push_back(fcs[31:24]);
  endtask

  task automatic send(input bit flip, input int er_idx, input int rst_at, input int rst_rel,
                      input int gap, input bit bad_pre);
    logic [7:0] pre [$];
    pre = {};
    if (bad_pre) begin
      pre.push_back(8'h55); pre.push_back(8'h55); pre.push_back(8'hAA);
    end else begin
      repeat (7) pre.push_back(8'h55);
      pre.push_back(8'hD5);
    end
    foreach (pre[i]) begin
      @(negedge clk);
      rx_dv = 1'b1; rx_er = 1'b0; rx_data = pre[i];
    end
    for (int i = 0; i < frm.size(); i++) begin
      @(negedge clk);
      rx_data = frm[i];
      if (flip && i == frm.size() - 1) rx_data = frm[i] ^ 8'h01;
      rx_er = (i == er_idx);
      if (i == rst_at)  rst = 1'b0;
      if (i == rst_rel) rst = 1'b1;
      if (i == 0) da0_cyc = cyc;
    end
    @(negedge clk);
    rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
    repeat (gap - 1) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid",  out_valid,  0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_ok",   frame_ok,   0);
    chk("rst_frame_len",  frame_len,  0);
    chk("rst_crc_err",    crc_err,    0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // good 64-byte unicast
    build(MAC_LOCAL, 64); snap();
    send(0, -1, -1, -1, 8, 0);
    chk("good_nbytes",  ov_cnt - ov0, 60);
    chk("good_sof_cnt", sof_cnt - sof0, 1);
    chk("good_sof_byte", sof_byte, 8'h02);
    chk("good_latency", sof_cyc - da0_cyc, 6);
    chk("good_done",    done_cnt - done0, 1);
    chk("good_ok",      frame_ok, 1);
    chk("good_crc_err", crc_err, 0);
    chk("good_len_err", len_err, 0);
    chk("good_len",     frame_len, 64);
    chk("good_data",    data_bad - bad0, 0);

    // last FCS byte corrupted
    build(MAC_LOCAL, 64); snap();
    send(1, -1, -1, -1, 8, 0);
    chk("fcs_nbytes",  ov_cnt - ov0, 60);
    chk("fcs_crc_err", crc_err, 1);
    chk("fcs_ok",      frame_ok, 0);
    chk("fcs_done",    done_cnt - done0, 1);

    // broadcast, maximum length
    build(MAC_BCAST, 1518); snap();
    send(0, -1, -1, -1, 8, 0);
    chk("max_ok",     frame_ok, 1);
    chk("max_len",    frame_len, 1518);
    chk("max_nbytes", ov_cnt - ov0, 1514);
    chk("max_data",   data_bad - bad0, 0);

    // one byte too long
    build(MAC_BCAST, 1519); snap();
    send(0, -1, -1, -1, 8, 0);
    chk("over_len_err", len_err, 1);
    chk("over_len",     frame_len, 1519);
    chk("over_ok",      frame_ok, 0);
    chk("over_done",    done_cnt - done0, 1);
    chk("over_nbytes",  ov_cnt - ov0, 1513);
    chk("over_data",    data_bad - bad0, 0);

    // foreign destination
    build(MAC_OTHER, 64); snap();
    send(0, -1, -1, -1, 8, 0);
`ifdef ETH_RX_MAC_FILTER_EN
    chk("miss_nbytes", ov_cnt - ov0, 0);
    chk("miss_done",   done_cnt - done0, 0);
`else
    chk("miss_nbytes", ov_cnt - ov0, 60);
    chk("miss_done",   done_cnt - done0, 1);
    chk("miss_ok",     frame_ok, 1);
`endif

    // PHY error on DA-relative byte 20
    build(MAC_LOCAL, 64); snap();
    send(0, 20, -1, -1, 8, 0);
    chk("phy_phy_err", phy_err, 1);
    chk("phy_ok",      frame_ok, 0);
    chk("phy_crc_err", crc_err, 0);

    // broken preamble: nothing out, previous status held
    build(MAC_LOCAL, 64); snap();
    send(0, -1, -1, -1, 8, 1);
    chk("pre_nbytes",   ov_cnt - ov0, 0);
    chk("pre_done",     done_cnt - done0, 0);
    chk("pre_hold_phy", phy_err, 1);

    // runt frame with valid FCS
    build(MAC_LOCAL, 40); snap();
    send(0, -1, -1, -1, 8, 0);
    chk("runt_len_err", len_err, 1);
    chk("runt_len",     frame_len, 40);
    chk("runt_ok",      frame_ok, 0);
    chk("runt_crc_err", crc_err, 0);
    chk("runt_nbytes",  ov_cnt - ov0, 36);

    // reset mid-frame, then a good frame
    build(MAC_LOCAL, 64); snap();
    send(0, -1, 30, 40, 8, 0);
    chk("rstmid_done", done_cnt - done0, 0);
    snap();
    send(0, -1, -1, -1, 8, 0);
    chk("rstmid_next_done", done_cnt - done0, 1);
    chk("rstmid_next_ok",   frame_ok, 1);
    chk("rstmid_next_len",  frame_len, 64);

    // back-to-back with a single idle cycle
    build(MAC_LOCAL, 64); snap();
    send(0, -1, -1, -1, 1, 0);
    send(0, -1, -1, -1, 8, 0);
    chk("b2b_done",   done_cnt - done0, 2);
    chk("b2b_nbytes", ov_cnt - ov0, 120);
    chk("b2b_ok",     frame_ok, 1);
    chk("b2b_data",   data_bad - bad0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
